// File: rtl/hazard_pkg.sv
// Shared types, register constants and helpers for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

    localparam logic [REG_W-1:0] REG_ZERO     = 5'd0;
    localparam logic [REG_W-1:0] REG_SWITCHES = 5'd30;
    localparam logic [REG_W-1:0] REG_PC       = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        VEC_WAIT = 1'b1
    } hz_state_t;

    // Registers whose value is not produced by the pipeline never forward or stall.
    function automatic logic is_fwdable(input logic [REG_W-1:0] r);
        return !((r == REG_ZERO) || (r == REG_SWITCHES) || (r == REG_PC));
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX operand; M stage wins over W stage.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] i_ra_e,
    input  logic [4:0] i_wa_m,
    input  logic [4:0] i_wa_w,
    input  logic       i_we_m,
    input  logic       i_we_w,
    output logic [1:0] o_fwd
);

    logic w_fwdable;

    assign w_fwdable = is_fwdable(i_ra_e);

    always_comb begin
        o_fwd = FWD_RF;
        if (w_fwdable && i_we_m && (i_wa_m == i_ra_e)) begin
            o_fwd = FWD_M;
        end else if (w_fwdable && i_we_w && (i_wa_w == i_ra_e)) begin
            o_fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: EX forwarding, load-use and SIMD-busy stalls, branch flushes.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned VEC_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] RA1D,
    input  logic [4:0] RA2D,
    input  logic [4:0] RA1E,
    input  logic [4:0] RA2E,
    input  logic [4:0] WA3E,
    input  logic [4:0] WA3M,
    input  logic [4:0] WA3W,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       BranchTakenE,
    input  logic       VecIssueE,
    input  logic       VecDone,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       Stall,
    output logic       VecTimeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_TIMEOUT - 1);

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] w_vec_cnt_nxt;
    logic             r_vec_timeout;
    logic             w_timeout_set;

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_ld_stall;
    logic       w_stall_f;
    logic       w_stall_d;
    logic       w_stall_e;
    logic       w_flush_d;
    logic       w_flush_e;
    logic       w_flush_m;

    hazard_fwd_sel u_fwd_a (
        .i_ra_e (RA1E),
        .i_wa_m (WA3M),
        .i_wa_w (WA3W),
        .i_we_m (RegWriteM),
        .i_we_w (RegWriteW),
        .o_fwd  (w_fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .i_ra_e (RA2E),
        .i_wa_m (WA3M),
        .i_wa_w (WA3W),
        .i_we_m (RegWriteM),
        .i_we_w (RegWriteW),
        .o_fwd  (w_fwd_b)
    );

    assign w_ld_stall = MemtoRegE && RegWriteE && is_fwdable(WA3E) &&
                        ((WA3E == RA1D) || (WA3E == RA2D));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_vec_cnt     <= '0;
            r_vec_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vec_cnt <= w_vec_cnt_nxt;
            if (w_timeout_set) begin
                r_vec_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_vec_cnt_nxt = r_vec_cnt;
        w_timeout_set = 1'b0;
        w_stall_f     = 1'b0;
        w_stall_d     = 1'b0;
        w_stall_e     = 1'b0;
        w_flush_d     = 1'b0;
        w_flush_e     = 1'b0;
        w_flush_m     = 1'b0;
        case (r_state)
            RUN: begin
                if (BranchTakenE) begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                end else if (w_ld_stall) begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_flush_e = 1'b1;
                end
                // A SIMD op that completes in its issue cycle never needs a wait.
                if (VecIssueE && !BranchTakenE && !VecDone) begin
                    w_state_nxt   = VEC_WAIT;
                    w_vec_cnt_nxt = '0;
                end
            end
            VEC_WAIT: begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_stall_e = 1'b1;
                w_flush_m = 1'b1;
                if (VecDone) begin
                    w_state_nxt = RUN;
                end else if (r_vec_cnt == CNT_LAST) begin
                    w_state_nxt   = RUN;
                    w_timeout_set = 1'b1;
                end else begin
                    w_vec_cnt_nxt = r_vec_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Outputs are held at zero while reset is asserted.
    assign ForwardAE  = rst_n ? w_fwd_a : FWD_RF;
    assign ForwardBE  = rst_n ? w_fwd_b : FWD_RF;
    assign StallF     = rst_n & w_stall_f;
    assign StallD     = rst_n & w_stall_d;
    assign StallE     = rst_n & w_stall_e;
    assign FlushD     = rst_n & w_flush_d;
    assign FlushE     = rst_n & w_flush_e;
    assign FlushM     = rst_n & w_flush_m;
    assign Stall      = rst_n & w_stall_d;
    assign VecTimeout = rst_n & r_vec_timeout;

endmodule
